vmx_issue_controller: RTL and testbench
=======================================

VMX_ISSUE_CONTROLLER -- requirements
Module: vmx_issue_controller

Interface
REQ-001 Parameter PE_SIZE, default 4: PE array dimension; data beats per job and result beats per MATMUL job.
REQ-002 Parameter PORT_WIDTH, default 16: element width; AEQ word is PORT_WIDTH*PE_SIZE bits, EAQ word is 2*PORT_WIDTH*PE_SIZE bits.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 sw_rst  in  1  synchronous active-high soft reset, same effect as rst_n.
REQ-006 job_valid / job_ready  in / out  1 / 1  host job handshake.
REQ-007 job_op  in  1  0=SETW (load weights), 1=MATMUL.
REQ-008 src_valid / src_ready / src_data  in / out / in  1 / 1 / 64  operand stream for the current job.
REQ-009 ISA_FIFO_WDATA / ISA_FIFO_WENA / ISA_FIFO_FULL  out / out / in  32 / 1 / 1  command FIFO write port.
REQ-010 AEQ_FIFO_WDATA / AEQ_FIFO_WENA / AEQ_FIFO_FULL  out / out / in  64 / 1 / 1  operand FIFO write port.
REQ-011 EAQ_FIFO_DATA / EAQ_FIFO_RENA / EAQ_FIFO_EMPTY  in / out / in  128 / 1 / 1  result FIFO read port, first-word-fall-through.
REQ-012 res_valid / res_ready / res_data / res_last  out / in / out / in... corrected: out / in / out / out  1 / 1 / 128 / 1  result stream to host.
REQ-013 busy  out  1  high while the FSM is not IDLE or MATMUL results are outstanding.

Function
REQ-014 The FSM SHALL have three states: IDLE, CMD, PUSH.
REQ-015 job_ready SHALL equal (state==IDLE); on job_valid&job_ready the FSM SHALL capture job_op and go to CMD.
REQ-016 In CMD: ISA_FIFO_WENA=!ISA_FIFO_FULL, ISA_FIFO_WDATA={31'b0,op}; on the write cycle go to PUSH with beat counter=0; while FULL, hold CMD.
REQ-017 In PUSH: src_ready=!AEQ_FIFO_FULL, AEQ_FIFO_WENA=src_valid&src_ready, AEQ_FIFO_WDATA=src_data (combinational, zero latency).
REQ-018 Each AEQ write SHALL increment the beat counter; the write with counter==PE_SIZE-1 SHALL return the FSM to IDLE.
REQ-019 Outside CMD/PUSH: ISA_FIFO_WENA, AEQ_FIFO_WENA, src_ready SHALL be 0; no FIFO write occurs while its FULL is 1.
REQ-020 A 4-bit outstanding counter SHALL increment on each MATMUL command write and decrement on the res_last handshake; both in the same cycle leave it unchanged.
REQ-021 The drain path SHALL run independently of the FSM: EAQ_FIFO_RENA=!EAQ_FIFO_EMPTY&(!res_valid|res_ready); on a read, res_data<=EAQ_FIFO_DATA and res_valid<=1 on the next edge.
REQ-022 res_valid SHALL clear after a res_valid&res_ready handshake with no simultaneous read; res_data SHALL hold while res_valid&!res_ready.
REQ-023 A result beat counter SHALL count handshakes modulo PE_SIZE; res_last=res_valid&(count==PE_SIZE-1).
REQ-024 busy SHALL equal (state!=IDLE)|(outstanding!=0).

Reset
REQ-025 On rst_n low or sw_rst high: FSM=IDLE; all counters=0; res_valid=0; res_data=0; all WENA/RENA outputs=0; job_ready=1 once released.
REQ-026 Reset mid-job SHALL abandon the partial job without completing its remaining FIFO writes.

Configuration
REQ-027 With VMX_ISSUE_PERF_EN defined, the block SHALL add outputs perf_jobs[15:0] (count of completed PUSH phases) and perf_stall[15:0] (cycles in CMD/PUSH with the target FIFO FULL). Both saturate at 16'hFFFF and clear on reset.
REQ-028 Without VMX_ISSUE_PERF_EN, these ports and counters SHALL NOT exist.

Structure
REQ-029 Shared package vmx_pkg SHALL hold the opcode constants (OP_SETW=0, OP_MATMUL=1) and the state encoding.
REQ-030 The drain path SHALL be a sub-module, vmx_result_drain.

Verification
REQ-031 SETW job, FIFOs never full: ISA write of 0 in cycle 1 after acceptance, then 4 AEQ writes on consecutive cycles; FSM in IDLE on the next cycle; busy=0.
REQ-032 MATMUL job with ISA_FIFO_FULL high for 3 cycles: no ISA_FIFO_WENA during those cycles; write of 1 in the cycle FULL drops; outstanding=1.
REQ-033 AEQ_FIFO_FULL toggled during PUSH: src_ready tracks !FULL; exactly 4 writes with data in order (0x1111.., 0x2222.., 0x3333.., 0x4444..).
REQ-034 4 EAQ words with res_ready low for 2 cycles: res_data stable while stalled; res_last on the 4th beat only; outstanding returns to 0 and busy=0.
REQ-035 rst_n asserted after 2 of 4 PUSH beats: all outputs at reset values immediately; the next job starts cleanly with CMD.
REQ-036 res_last handshake in the same cycle as a MATMUL command write: outstanding stays unchanged.

Source files
------------

// File: rtl/vmx_pkg.sv
// Shared opcode constants and issue-FSM state encoding for the VMX issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vmx_pkg;

  localparam logic OP_SETW   = 1'b0;
  localparam logic OP_MATMUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

endpackage

// File: rtl/vmx_result_drain.sv
// Drains the first-word-fall-through result FIFO into a registered valid/ready stream, tagging the last beat of each job.
// Latency: one cycle from an EAQ read to res_valid.
// Backpressure: reads stop while res_valid is held and res_ready is low; res_data stays stable until it is accepted.
module vmx_result_drain #(
  parameter int PE_SIZE = 4,
  parameter int DW      = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sw_rst,
  input  logic [DW-1:0] eaq_data,
  input  logic          eaq_empty,
  output logic          eaq_rena,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last
);

  localparam int CW = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PE_SIZE - 1);

  logic [CW-1:0] beat_cnt;
  logic          handshake;

  // Reads are suppressed while any reset is applied so no word is lost from the FIFO.
  assign eaq_rena  = rst_n & ~sw_rst & ~eaq_empty & (~res_valid | res_ready);
  assign handshake = res_valid & res_ready;
  assign res_last  = res_valid & (beat_cnt == LAST_BEAT);

  // Output register: load on a read, drop valid once the held beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (sw_rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (eaq_rena) begin
      res_valid <= 1'b1;
      res_data  <= eaq_data;
    end else if (handshake) begin
      res_valid <= 1'b0;
    end
  end

  // Beat position within the current job's result burst, wrapping every PE_SIZE beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (sw_rst) begin
      beat_cnt <= '0;
    end else if (handshake) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vmx_issue_controller.sv
// Accepts host jobs, writes one ISA command then PE_SIZE operand beats into the array FIFOs, and drains results to the host.
// Latency: command written the cycle after job acceptance; operand beats pass through combinationally; results one cycle after EAQ read.
// Backpressure: holds in CMD/PUSH while the target FIFO is FULL; result path stalls on res_ready. Define VMX_ISSUE_PERF_EN for perf counters.
module vmx_issue_controller
  import vmx_pkg::*;
#(
  parameter int PE_SIZE    = 4,
  parameter int PORT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_rst,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic                          job_op,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [PORT_WIDTH*PE_SIZE-1:0] src_data,
  output logic [31:0]                   ISA_FIFO_WDATA,
  output logic                          ISA_FIFO_WENA,
  input  logic                          ISA_FIFO_FULL,
  output logic [PORT_WIDTH*PE_SIZE-1:0] AEQ_FIFO_WDATA,
  output logic                          AEQ_FIFO_WENA,
  input  logic                          AEQ_FIFO_FULL,
  input  logic [2*PORT_WIDTH*PE_SIZE-1:0] EAQ_FIFO_DATA,
  output logic                          EAQ_FIFO_RENA,
  input  logic                          EAQ_FIFO_EMPTY,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*PORT_WIDTH*PE_SIZE-1:0] res_data,
  output logic                          res_last,
`ifdef VMX_ISSUE_PERF_EN
  output logic [15:0]                   perf_jobs,
  output logic [15:0]                   perf_stall,
`endif
  output logic                          busy
);

  localparam int CW = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PE_SIZE - 1);

  state_t        state, state_nxt;
  logic          op_q;
  logic [CW-1:0] beat_cnt;
  logic [3:0]    outstanding;
  logic          push_done;
  logic          mm_issue;
  logic          mm_retire;

  // Next-state and FIFO write strobes; soft reset masks every write in the cycle it is applied.
  always_comb begin
    state_nxt      = state;
    job_ready      = 1'b0;
    src_ready      = 1'b0;
    ISA_FIFO_WENA  = 1'b0;
    ISA_FIFO_WDATA = {31'b0, op_q};
    AEQ_FIFO_WENA  = 1'b0;
    AEQ_FIFO_WDATA = src_data;
    push_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        ISA_FIFO_WENA = ~ISA_FIFO_FULL;
        if (!ISA_FIFO_FULL) state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        src_ready     = ~AEQ_FIFO_FULL;
        AEQ_FIFO_WENA = src_valid & ~AEQ_FIFO_FULL;
        push_done     = AEQ_FIFO_WENA & (beat_cnt == LAST_BEAT);
        if (push_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (sw_rst) begin
      src_ready     = 1'b0;
      ISA_FIFO_WENA = 1'b0;
      AEQ_FIFO_WENA = 1'b0;
      push_done     = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= ST_IDLE;
    else if (sw_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Latch the opcode at acceptance and track operand beats within the push phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_SETW;
      beat_cnt <= '0;
    end else if (sw_rst) begin
      op_q     <= OP_SETW;
      beat_cnt <= '0;
    end else begin
      if (job_valid && job_ready) op_q <= job_op;
      if (ISA_FIFO_WENA)          beat_cnt <= '0;
      else if (AEQ_FIFO_WENA)     beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign mm_issue  = ISA_FIFO_WENA & (op_q == OP_MATMUL);
  assign mm_retire = res_last & res_ready;

  // MATMUL jobs whose last result beat has not yet been accepted by the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     outstanding <= 4'd0;
    else if (sw_rst)                outstanding <= 4'd0;
    else if (mm_issue && !mm_retire) outstanding <= outstanding + 4'd1;
    else if (!mm_issue && mm_retire) outstanding <= outstanding - 4'd1;
  end

  assign busy = (state != ST_IDLE) | (outstanding != 4'd0);

  vmx_result_drain #(
    .PE_SIZE (PE_SIZE),
    .DW      (2*PORT_WIDTH*PE_SIZE)
  ) u_drain (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst    (sw_rst),
    .eaq_data  (EAQ_FIFO_DATA),
    .eaq_empty (EAQ_FIFO_EMPTY),
    .eaq_rena  (EAQ_FIFO_RENA),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last)
  );

`ifdef VMX_ISSUE_PERF_EN
  logic stall_cyc;
  assign stall_cyc = ((state == ST_CMD) & ISA_FIFO_FULL) | ((state == ST_PUSH) & AEQ_FIFO_FULL);

  // Saturating counts of completed push phases and FIFO-full stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs  <= 16'd0;
      perf_stall <= 16'd0;
    end else if (sw_rst) begin
      perf_jobs  <= 16'd0;
      perf_stall <= 16'd0;
    end else begin
      if (push_done && perf_jobs != 16'hFFFF)  perf_jobs  <= perf_jobs + 16'd1;
      if (stall_cyc && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vmx_issue_controller.sv
// Directed bench for vmx_issue_controller: job issue, FIFO-full stalls, result drain, resets.
// Latency: n/a.
// Backpressure: bench models a first-word-fall-through EAQ FIFO and drives FULL flags directly.
module tb_vmx_issue_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sw_rst = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic         job_op = 1'b0;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [63:0]  src_data = '0;
  logic [31:0]  ISA_FIFO_WDATA;
  logic         ISA_FIFO_WENA;
  logic         ISA_FIFO_FULL = 1'b0;
  logic [63:0]  AEQ_FIFO_WDATA;
  logic         AEQ_FIFO_WENA;
  logic         AEQ_FIFO_FULL = 1'b0;
  logic [127:0] EAQ_FIFO_DATA;
  logic         EAQ_FIFO_RENA;
  logic         EAQ_FIFO_EMPTY;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         res_last;
  logic         busy;
`ifdef VMX_ISSUE_PERF_EN
  logic [15:0]  perf_jobs;
  logic [15:0]  perf_stall;
`endif

  int total = 0;
  int bad = 0;

  logic [127:0] eaq_mem [0:15];
  logic [3:0]   eaq_wr = 4'd0;
  logic [3:0]   eaq_rd = 4'd0;

  assign EAQ_FIFO_EMPTY = (eaq_rd == eaq_wr);
  assign EAQ_FIFO_DATA  = eaq_mem[eaq_rd];

  always @(posedge clk) if (EAQ_FIFO_RENA && !EAQ_FIFO_EMPTY) eaq_rd <= eaq_rd + 4'd1;

  always #5 clk = ~clk;

  vmx_issue_controller #(.PE_SIZE(4), .PORT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_rst         (sw_rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_op         (job_op),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_data       (src_data),
    .ISA_FIFO_WDATA (ISA_FIFO_WDATA),
    .ISA_FIFO_WENA  (ISA_FIFO_WENA),
    .ISA_FIFO_FULL  (ISA_FIFO_FULL),
    .AEQ_FIFO_WDATA (AEQ_FIFO_WDATA),
    .AEQ_FIFO_WENA  (AEQ_FIFO_WENA),
    .AEQ_FIFO_FULL  (AEQ_FIFO_FULL),
    .EAQ_FIFO_DATA  (EAQ_FIFO_DATA),
    .EAQ_FIFO_RENA  (EAQ_FIFO_RENA),
    .EAQ_FIFO_EMPTY (EAQ_FIFO_EMPTY),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_last       (res_last),
`ifdef VMX_ISSUE_PERF_EN
    .perf_jobs      (perf_jobs),
    .perf_stall     (perf_stall),
`endif
    .busy           (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_word(input int i);
    logic [15:0] e;
    e = 16'h1111 * 16'(i + 1);
    return {4{e}};
  endfunction

  function automatic logic [127:0] res_word(input int i);
    logic [15:0] e;
    e = 16'hA000 + 16'(i);
    return {8{e}};
  endfunction

  // Pushes PE_SIZE beats into a job already in PUSH with AEQ never full.
  task automatic push_four(input string tag);
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = beat_word(i);
      #1;
      total++;
      if (AEQ_FIFO_WENA !== 1'b1 || AEQ_FIFO_WDATA !== beat_word(i)) begin
        bad++;
        $display("FAIL %s beat%0d wena=%b data=%h expected wena=1 data=%h", tag, i, AEQ_FIFO_WENA, AEQ_FIFO_WDATA, beat_word(i));
      end
      step();
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (job_ready !== 1'b1 || ISA_FIFO_WENA !== 1'b0 || AEQ_FIFO_WENA !== 1'b0 || EAQ_FIFO_RENA !== 1'b0 ||
        src_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 128'd0 || busy !== 1'b0 || res_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_values jr=%b isa=%b aeq=%b rena=%b srdy=%b rv=%b rd=%h busy=%b last=%b expected 1,0,0,0,0,0,0,0,0",
               job_ready, ISA_FIFO_WENA, AEQ_FIFO_WENA, EAQ_FIFO_RENA, src_ready, res_valid, res_data, busy, res_last);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_setw();
    job_valid = 1'b1;
    job_op    = 1'b0;
    #1;
    total++;
    if (job_ready !== 1'b1 || ISA_FIFO_WENA !== 1'b0) begin
      bad++;
      $display("FAIL setw_accept job_ready=%b isa_wena=%b expected 1 0", job_ready, ISA_FIFO_WENA);
    end
    step();
    job_valid = 1'b0;
    #1;
    total++;
    if (ISA_FIFO_WENA !== 1'b1 || ISA_FIFO_WDATA !== 32'd0 || job_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL setw_cmd wena=%b wdata=%h jr=%b busy=%b expected 1 0 0 1", ISA_FIFO_WENA, ISA_FIFO_WDATA, job_ready, busy);
    end
    step();
    push_four("setw_push");
    total++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || AEQ_FIFO_WENA !== 1'b0 || src_ready !== 1'b0) begin
      bad++;
      $display("FAIL setw_idle jr=%b busy=%b aeq=%b srdy=%b expected 1 0 0 0", job_ready, busy, AEQ_FIFO_WENA, src_ready);
    end
  endtask

  task automatic test_matmul_stall();
    int k;
    int c;
    ISA_FIFO_FULL = 1'b1;
    job_valid = 1'b1;
    job_op    = 1'b1;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ISA_FIFO_WENA !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL isa_full_hold cyc%0d wena=%b busy=%b expected 0 1", i, ISA_FIFO_WENA, busy);
      end
      step();
    end
    ISA_FIFO_FULL = 1'b0;
    #1;
    total++;
    if (ISA_FIFO_WENA !== 1'b1 || ISA_FIFO_WDATA !== 32'd1) begin
      bad++;
      $display("FAIL isa_release wena=%b wdata=%h expected 1 1", ISA_FIFO_WENA, ISA_FIFO_WDATA);
    end
    step();
    total++;
    if (dut.outstanding !== 4'd1) begin
      bad++;
      $display("FAIL outstanding_inc got=%0d expected 1", dut.outstanding);
    end
    // AEQ FULL toggles every other cycle, starting full
    k = 0;
    c = 0;
    while (k < 4 && c < 20) begin
      AEQ_FIFO_FULL = (c % 2 == 0);
      src_valid = 1'b1;
      src_data  = beat_word(k);
      #1;
      total++;
      if (src_ready !== !AEQ_FIFO_FULL) begin
        bad++;
        $display("FAIL aeq_src_ready cyc%0d got=%b expected %b", c, src_ready, !AEQ_FIFO_FULL);
      end
      if (AEQ_FIFO_WENA) begin
        total++;
        if (AEQ_FIFO_WDATA !== beat_word(k) || AEQ_FIFO_FULL !== 1'b0) begin
          bad++;
          $display("FAIL aeq_toggle_data beat%0d got=%h expected %h (full=%b)", k, AEQ_FIFO_WDATA, beat_word(k), AEQ_FIFO_FULL);
        end
        k++;
      end
      step();
      c++;
    end
    src_valid = 1'b0;
    AEQ_FIFO_FULL = 1'b0;
    #1;
    total++;
    if (k !== 4 || c !== 8 || job_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL aeq_toggle_end writes=%0d cycles=%0d jr=%b busy=%b expected 4 8 1 1", k, c, job_ready, busy);
    end
  endtask

  task automatic test_drain();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) eaq_mem[i] = res_word(i);
    eaq_wr = 4'd4;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== res_word(0) || res_last !== 1'b0 || EAQ_FIFO_RENA !== 1'b0) begin
        bad++;
        $display("FAIL drain_stall cyc%0d rv=%b rd=%h last=%b rena=%b expected 1 %h 0 0", i, res_valid, res_data, res_last, EAQ_FIFO_RENA, res_word(0));
      end
      step();
    end
    res_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      total++;
      if (res_valid !== 1'b1 || res_data !== res_word(b) || res_last !== (b == 3)) begin
        bad++;
        $display("FAIL drain_beat%0d rv=%b rd=%h last=%b expected 1 %h %b", b, res_valid, res_data, res_last, res_word(b), (b == 3));
      end
      step();
    end
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || dut.outstanding !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_done rv=%b outstanding=%0d busy=%b expected 0 0 0", res_valid, dut.outstanding, busy);
    end
  endtask

  task automatic test_sw_rst();
    job_valid = 1'b1;
    job_op    = 1'b1;
    step();
    job_valid = 1'b0;
    sw_rst    = 1'b1;
    #1;
    total++;
    if (ISA_FIFO_WENA !== 1'b0) begin
      bad++;
      $display("FAIL sw_rst_mask isa_wena=%b expected 0", ISA_FIFO_WENA);
    end
    step();
    sw_rst = 1'b0;
    #1;
    total++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || dut.outstanding !== 4'd0) begin
      bad++;
      $display("FAIL sw_rst_state jr=%b busy=%b outstanding=%0d expected 1 0 0", job_ready, busy, dut.outstanding);
    end
  endtask

  task automatic test_rst_mid_job();
    job_valid = 1'b1;
    job_op    = 1'b0;
    step();
    job_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      src_valid = 1'b1;
      src_data  = beat_word(i);
      step();
    end
    src_data = beat_word(2);
    rst_n    = 1'b0;
    #1;
    total++;
    if (AEQ_FIFO_WENA !== 1'b0 || src_ready !== 1'b0 || ISA_FIFO_WENA !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_job aeq=%b srdy=%b isa=%b jr=%b busy=%b expected 0 0 0 1 0", AEQ_FIFO_WENA, src_ready, ISA_FIFO_WENA, job_ready, busy);
    end
    step();
    rst_n     = 1'b1;
    src_valid = 1'b0;
    step();
    job_valid = 1'b1;
    job_op    = 1'b0;
    #1;
    total++;
    if (job_ready !== 1'b1 || AEQ_FIFO_WENA !== 1'b0) begin
      bad++;
      $display("FAIL rst_restart_accept jr=%b aeq=%b expected 1 0", job_ready, AEQ_FIFO_WENA);
    end
    step();
    job_valid = 1'b0;
    #1;
    total++;
    if (ISA_FIFO_WENA !== 1'b1 || ISA_FIFO_WDATA !== 32'd0 || AEQ_FIFO_WENA !== 1'b0) begin
      bad++;
      $display("FAIL rst_restart_cmd isa=%b wdata=%h aeq=%b expected 1 0 0", ISA_FIFO_WENA, ISA_FIFO_WDATA, AEQ_FIFO_WENA);
    end
    step();
    push_four("rst_restart_push");
    total++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_restart_end jr=%b busy=%b expected 1 0", job_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    // first MATMUL job
    job_valid = 1'b1;
    job_op    = 1'b1;
    step();
    job_valid = 1'b0;
    step();
    push_four("b2b_push1");
    for (int i = 0; i < 4; i++) eaq_mem[4'(eaq_wr + 4'(i))] = res_word(4 + i);
    eaq_wr = eaq_wr + 4'd4;
    step();
    res_ready = 1'b1;
    step();
    step();
    step();
    res_ready = 1'b0;
    total++;
    if (res_last !== 1'b1 || res_data !== res_word(7) || dut.outstanding !== 4'd1) begin
      bad++;
      $display("FAIL b2b_hold_last last=%b rd=%h outstanding=%0d expected 1 %h 1", res_last, res_data, dut.outstanding, res_word(7));
    end
    // second MATMUL job: its command write coincides with the last-beat handshake
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    total++;
    if (ISA_FIFO_WENA !== 1'b1 || ISA_FIFO_WDATA !== 32'd1 || res_last !== 1'b1) begin
      bad++;
      $display("FAIL b2b_coincide isa=%b wdata=%h last=%b expected 1 1 1", ISA_FIFO_WENA, ISA_FIFO_WDATA, res_last);
    end
    step();
    res_ready = 1'b0;
    total++;
    if (dut.outstanding !== 4'd1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_outstanding got=%0d rv=%b expected 1 0", dut.outstanding, res_valid);
    end
    push_four("b2b_push2");
    total++;
    if (job_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end jr=%b busy=%b expected 1 1", job_ready, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) eaq_mem[i] = '0;
    test_reset();
    test_setw();
    test_matmul_stall();
    test_drain();
    test_sw_rst();
    test_rst_mid_job();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
